// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared constants for the instruction-memory fetch/load controller.
// State codes are plain constants so legacy tools can consume them.
package imem_ctrl_pkg;
   localparam int INSTR_BYTES = 2;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOAD_HI = 3'd1;
   localparam logic [2:0] ST_LOAD_LO = 3'd2;
   localparam logic [2:0] ST_LOAD_WR = 3'd3;
   localparam logic [2:0] ST_RUN     = 3'd4;
endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of load, fetch-control, memory and decode-side signals of the controller.
// master = controller side, slave = environment (memory, loader, decode).
interface imem_fetch_ctrl_if #(
   parameter int PROG_CTR_WID = 10,
   parameter int INSTR_WID    = 16
);
   logic                    run_en;
   logic                    load_req;
   logic                    load_valid;
   logic [7:0]              load_byte;
   logic                    load_ready;
   logic                    load_done;
   logic                    branch_taken;
   logic [PROG_CTR_WID-1:0] branch_target;
   logic                    stall;
   logic [PROG_CTR_WID-1:0] mem_addr;
   logic                    mem_we;
   logic [INSTR_WID-1:0]    mem_wdata;
   logic [INSTR_WID-1:0]    mem_rdata;
   logic [INSTR_WID-1:0]    instr_out;
   logic [PROG_CTR_WID-1:0] prog_ctr;
   logic                    instr_valid;

   modport master (
      input  run_en, load_req, load_valid, load_byte, branch_taken, branch_target,
             stall, mem_rdata,
      output load_ready, load_done, mem_addr, mem_we, mem_wdata, instr_out,
             prog_ctr, instr_valid
   );

   modport slave (
      output run_en, load_req, load_valid, load_byte, branch_taken, branch_target,
             stall, mem_rdata,
      input  load_ready, load_done, mem_addr, mem_we, mem_wdata, instr_out,
             prog_ctr, instr_valid
   );
endinterface

// File: rtl/imem_fetch_ctrl_load_assembler.sv
// Packs the high-byte-first load stream into one instruction word.
// Abort drops any half-assembled word so it can never reach memory.
module imem_load_assembler
   import imem_ctrl_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       active,
   input  logic                       want_lo,
   input  logic                       abort,
   input  logic                       byte_valid,
   input  logic [7:0]                 byte_in,
   output logic                       byte_ready,
   output logic                       hi_taken,
   output logic                       lo_taken,
   output logic [8*INSTR_BYTES-1:0]   word
);
   logic [7:0] hi;
   logic [7:0] lo;

   assign byte_ready = active;
   assign hi_taken   = active && byte_valid && !abort && !want_lo;
   assign lo_taken   = active && byte_valid && !abort &&  want_lo;
   assign word       = {hi, lo};

   always_ff @(posedge clk) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (abort) begin
         hi <= '0;
         lo <= '0;
      end else begin
         if (hi_taken) hi <= byte_in;
         if (lo_taken) lo <= byte_in;
      end
   end
endmodule

// File: rtl/imem_fetch_ctrl.sv
// Sole owner of the instruction memory port: byte-stream program load,
// then pipelined fetch with stall hold and branch redirect.
module imem_fetch_ctrl
   import imem_ctrl_pkg::*;
#(
   parameter int PROG_CTR_WID = 10,
   parameter int INSTR_WID    = 16
)(
   input  logic               clk,
   input  logic               reset,
   imem_fetch_ctrl_if.master  bus
);
   logic [2:0]              state;
   logic [PROG_CTR_WID-1:0] fetch_pc;
   logic [PROG_CTR_WID-1:0] pend_pc;
   logic [PROG_CTR_WID-1:0] load_addr;
   logic [PROG_CTR_WID-1:0] prog_ctr_q;
   logic [INSTR_WID-1:0]    instr_q;
   logic                    pend;
   logic                    instr_valid_q;
   logic                    load_done_q;

   logic                    load_active;
   logic                    load_abort;
   logic                    hi_taken;
   logic                    lo_taken;
   logic [INSTR_WID-1:0]    word;

   assign load_active = (state == ST_LOAD_HI) || (state == ST_LOAD_LO);
   assign load_abort  = load_active && !bus.load_req;

   imem_load_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .active     (load_active),
      .want_lo    (state == ST_LOAD_LO),
      .abort      (load_abort),
      .byte_valid (bus.load_valid),
      .byte_in    (bus.load_byte),
      .byte_ready (bus.load_ready),
      .hi_taken   (hi_taken),
      .lo_taken   (lo_taken),
      .word       (word)
   );

   // While stalled, re-read the in-flight word so mem_rdata is still valid on release.
   always_comb begin
      bus.mem_addr = fetch_pc;
      case (state)
         ST_LOAD_WR: bus.mem_addr = load_addr;
         ST_RUN:     bus.mem_addr = bus.stall ? pend_pc : fetch_pc;
         default:    bus.mem_addr = fetch_pc;
      endcase
   end

   assign bus.mem_we      = (state == ST_LOAD_WR);
   assign bus.mem_wdata   = word;
   assign bus.load_done   = load_done_q;
   assign bus.instr_out   = instr_q;
   assign bus.prog_ctr    = prog_ctr_q;
   assign bus.instr_valid = instr_valid_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         fetch_pc      <= '0;
         pend_pc       <= '0;
         load_addr     <= '0;
         prog_ctr_q    <= '0;
         instr_q       <= '0;
         pend          <= 1'b0;
         instr_valid_q <= 1'b0;
         load_done_q   <= 1'b0;
      end else begin
         load_done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.load_req) begin
                  state     <= ST_LOAD_HI;
                  load_addr <= '0;
               end else if (bus.run_en) begin
                  state <= ST_RUN;
               end
            end
            ST_LOAD_HI: begin
               if (!bus.load_req) begin
                  state       <= ST_IDLE;
                  load_done_q <= 1'b1;
               end else if (hi_taken) begin
                  state <= ST_LOAD_LO;
               end
            end
            ST_LOAD_LO: begin
               if (!bus.load_req) begin
                  state       <= ST_IDLE;
                  load_done_q <= 1'b1;
               end else if (lo_taken) begin
                  state <= ST_LOAD_WR;
               end
            end
            ST_LOAD_WR: begin
               load_addr <= load_addr + 1'b1;
               if (&load_addr) begin
                  state       <= ST_IDLE;
                  load_done_q <= 1'b1;
               end else begin
                  state <= ST_LOAD_HI;
               end
            end
            ST_RUN: begin
               if (!bus.stall) begin
                  if (!bus.run_en) begin
                     state         <= ST_IDLE;
                     pend          <= 1'b0;
                     instr_valid_q <= 1'b0;
                  end else if (bus.branch_taken) begin
                     fetch_pc      <= bus.branch_target;
                     pend          <= 1'b0;
                     instr_valid_q <= 1'b0;
                  end else begin
                     pend     <= 1'b1;
                     pend_pc  <= fetch_pc;
                     fetch_pc <= fetch_pc + 1'b1;
                     if (pend) begin
                        instr_q       <= bus.mem_rdata;
                        prog_ctr_q    <= pend_pc;
                        instr_valid_q <= 1'b1;
                     end else begin
                        instr_valid_q <= 1'b0;
                     end
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: load table, hand-written fetch corners,
// then randomized stall/branch traffic against an in-order fetch-stream model.
module tb_imem_fetch_ctrl;
   localparam int W  = 10;
   localparam int IW = 16;
   localparam int DEPTH = 1 << W;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   imem_fetch_ctrl_if #(.PROG_CTR_WID(W), .INSTR_WID(IW)) bus ();
   imem_fetch_ctrl #(.PROG_CTR_WID(W), .INSTR_WID(IW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Instruction memory with registered read; bk_* is the bench preload path.
   logic [IW-1:0] mem [DEPTH];
   logic          bk_we;
   logic [W-1:0]  bk_addr;
   logic [IW-1:0] bk_data;
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else if (bk_we) mem[bk_addr] <= bk_data;
      bus.mem_rdata <= mem[bus.mem_addr];
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string name, input logic [W-1:0] pc);
      chk({name, ".valid"}, 32'(bus.instr_valid), 32'd1);
      chk({name, ".pc"}, 32'(bus.prog_ctr), 32'(pc));
      chk({name, ".instr"}, 32'(bus.instr_out), 32'(mem[pc]));
   endtask

   typedef struct {
      logic       req;
      logic       vld;
      logic [7:0] byt;
      logic       rdy;
      logic       we;
      logic       done;
      logic [W-1:0]  addr;
      logic [IW-1:0] wdata;
   } ld_vec_t;

   ld_vec_t tbl [11];

   logic [W-1:0]  exp_pc;
   logic [W-1:0]  p_pc;
   logic [IW-1:0] p_instr;
   logic          p_valid;
   logic          brn;
   int            n_out;

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0};
      tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 10'h0, 16'h0};
      tbl[2]  = '{1'b1, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 10'h0, 16'h0};
      tbl[3]  = '{1'b1, 1'b1, 8'h34, 1'b1, 1'b0, 1'b0, 10'h0, 16'h0};
      tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 10'h0, 16'h1234};
      tbl[5]  = '{1'b1, 1'b1, 8'hAB, 1'b1, 1'b0, 1'b0, 10'h0, 16'h0};
      tbl[6]  = '{1'b1, 1'b1, 8'hCD, 1'b1, 1'b0, 1'b0, 10'h0, 16'h0};
      tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 10'h1, 16'hABCD};
      tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 10'h0, 16'h0};
      tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 10'h0, 16'h0};
      tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'h0, 16'h0};

      reset = 1'b1;
      bus.run_en = 1'b0; bus.load_req = 1'b0; bus.load_valid = 1'b0; bus.load_byte = '0;
      bus.branch_taken = 1'b0; bus.branch_target = '0; bus.stall = 1'b0;
      bk_we = 1'b1; bk_addr = '0; bk_data = '0;

      // Preload random contents while held in reset; mem[2] is a sentinel.
      for (int i = 0; i < DEPTH; i++) begin
         bk_addr = W'(i);
         bk_data = (i == 2) ? 16'h5A5A : IW'($urandom);
         tick();
      end
      bk_we = 1'b0;
      tick();
      chk("rst.valid", 32'(bus.instr_valid), 32'd0);
      chk("rst.pc", 32'(bus.prog_ctr), 32'd0);
      chk("rst.instr", 32'(bus.instr_out), 32'd0);
      chk("rst.we", 32'(bus.mem_we), 32'd0);
      chk("rst.done", 32'(bus.load_done), 32'd0);
      chk("rst.ready", 32'(bus.load_ready), 32'd0);
      reset = 1'b0;

      // Table-driven load of 12 34 AB CD, then load_req dropped.
      for (int i = 0; i < 11; i++) begin
         bus.load_req = tbl[i].req; bus.load_valid = tbl[i].vld; bus.load_byte = tbl[i].byt;
         #1;
         chk($sformatf("ld[%0d].ready", i), 32'(bus.load_ready), 32'(tbl[i].rdy));
         chk($sformatf("ld[%0d].we", i), 32'(bus.mem_we), 32'(tbl[i].we));
         chk($sformatf("ld[%0d].done", i), 32'(bus.load_done), 32'(tbl[i].done));
         if (tbl[i].we) begin
            chk($sformatf("ld[%0d].addr", i), 32'(bus.mem_addr), 32'(tbl[i].addr));
            chk($sformatf("ld[%0d].wdata", i), 32'(bus.mem_wdata), 32'(tbl[i].wdata));
         end
         tick();
      end
      chk("ld.mem0", 32'(mem[0]), 32'h1234);
      chk("ld.mem1", 32'(mem[1]), 32'hABCD);
      chk("ld.mem2", 32'(mem[2]), 32'h5A5A);

      // Reset after one load byte: nothing written, then a clean re-load from 0.
      bus.load_req = 1'b1; tick();
      bus.load_valid = 1'b1; bus.load_byte = 8'h55; tick();
      bus.load_valid = 1'b0; bus.load_req = 1'b0; reset = 1'b1; tick();
      reset = 1'b0; #1;
      chk("rl.ready", 32'(bus.load_ready), 32'd0);
      chk("rl.we", 32'(bus.mem_we), 32'd0);
      chk("rl.mem0", 32'(mem[0]), 32'h1234);
      bus.load_req = 1'b1; tick();
      bus.load_valid = 1'b1; bus.load_byte = 8'h9A; tick();
      bus.load_byte = 8'hBC; tick();
      bus.load_valid = 1'b0; bus.load_req = 1'b0;
      chk("rl.we1", 32'(bus.mem_we), 32'd1);
      chk("rl.addr", 32'(bus.mem_addr), 32'd0);
      chk("rl.wdata", 32'(bus.mem_wdata), 32'h9ABC);
      tick(); tick();
      chk("rl.done", 32'(bus.load_done), 32'd1);
      chk("rl.mem0b", 32'(mem[0]), 32'h9ABC);

      // Fetch from reset with mem[0..3] = A0..A3.
      bk_we = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bk_addr = W'(i); bk_data = 16'h00A0 + IW'(i); tick();
      end
      bk_we = 1'b0;
      reset = 1'b1; bus.run_en = 1'b1; tick();
      reset = 1'b0;
      tick(); chk("run.c1.valid", 32'(bus.instr_valid), 32'd0);
      tick(); chk("run.c2.valid", 32'(bus.instr_valid), 32'd0);
      tick(); chk_out("run.c3", 10'h000);
      chk("run.c3.a0", 32'(bus.instr_out), 32'h00A0);
      tick(); chk_out("run.c4", 10'h001);

      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); chk_out($sformatf("stall%0d", i), 10'h001);
      end
      bus.stall = 1'b0;
      tick(); chk_out("rel.pc2", 10'h002);
      chk("rel.a2", 32'(bus.instr_out), 32'h00A2);

      bus.branch_taken = 1'b1; bus.branch_target = 10'h200;
      tick(); chk("br.valid0", 32'(bus.instr_valid), 32'd0);
      bus.branch_taken = 1'b0;
      tick(); chk("br.valid1", 32'(bus.instr_valid), 32'd0);
      tick(); chk_out("br.200", 10'h200);
      tick(); chk_out("br.201", 10'h201);

      bus.branch_taken = 1'b1; bus.branch_target = 10'h3FE;
      tick(); bus.branch_taken = 1'b0;
      tick();
      tick(); chk_out("wrap.3fe", 10'h3FE);
      tick(); chk_out("wrap.3ff", 10'h3FF);
      tick(); chk_out("wrap.000", 10'h000);

      // Stop and resume: the squashed in-flight word (0x001) is skipped.
      bus.run_en = 1'b0;
      tick(); chk("stop.valid", 32'(bus.instr_valid), 32'd0);
      tick(); tick();
      chk("stop.idle", 32'(bus.instr_valid), 32'd0);
      bus.run_en = 1'b1;
      tick(); tick(); tick(); chk_out("resume", 10'h002);

      // Random stall/branch/load_req traffic; model = in-order stream from the last target.
      n_out = 0;
      exp_pc = '0;
      for (int i = 0; i < 400; i++) begin
         bus.stall = (i == 0) ? 1'b0 : ($urandom_range(0, 9) < 3);
         brn = (i == 0) ? 1'b1 : ($urandom_range(0, 19) == 0);
         bus.branch_taken = brn;
         bus.branch_target = W'($urandom_range(0, DEPTH - 1));
         bus.load_req = ($urandom_range(0, 3) == 0);
         p_pc = bus.prog_ctr; p_instr = bus.instr_out; p_valid = bus.instr_valid;
         tick();
         if (bus.stall) begin
            chk("rnd.hold.valid", 32'(bus.instr_valid), 32'(p_valid));
            chk("rnd.hold.pc", 32'(bus.prog_ctr), 32'(p_pc));
            chk("rnd.hold.instr", 32'(bus.instr_out), 32'(p_instr));
         end else if (brn) begin
            chk("rnd.squash", 32'(bus.instr_valid), 32'd0);
            exp_pc = bus.branch_target;
         end else if (bus.instr_valid) begin
            chk("rnd.pc", 32'(bus.prog_ctr), 32'(exp_pc));
            chk("rnd.instr", 32'(bus.instr_out), 32'(mem[exp_pc]));
            exp_pc = exp_pc + 1'b1;
            n_out++;
         end
         #1;
         chk("rnd.no_we", 32'(bus.mem_we), 32'd0);
         chk("rnd.no_ready", 32'(bus.load_ready), 32'd0);
      end
      chk("rnd.progress", 32'(n_out > 100), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
